stream_mux_arb_v2: RTL
======================

Name: stream_mux_arb_v2

Overview:
- Parametrised, registered N-to-1 stream multiplexer with a valid/ready handshake on every input and on the output.
- It is the next generation of the combinational 2/4/8-way muxes. Input count is generic, and the select is produced internally by fixed-priority, round-robin or forced selection.
- It adds one output pipeline register and backpressure.
- It is used to merge request streams, for example fetch/LSU/debug onto a single memory port.

Parameters:
- width, 32, data bits per channel
- num_inputs, 4, number of input channels (2..16)
- sel_width is a localparam, not a parameter: $clog2(num_inputs), minimum 1.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous, active-high reset
- in_data  input  num_inputs*width  packed channel data; channel i occupies [i*width +: width]
- in_valid  input  num_inputs  channel i holds valid data
- in_ready  output  num_inputs  channel i is transferred this cycle when in_valid[i] and in_ready[i] are both high
- out_data  output  width  registered selected data
- out_valid  output  1  out_data is valid
- out_ready  input  1  downstream accepts out_data
- out_sel  output  sel_width  index of the channel that produced out_data
- mode  input  2  selection mode: 00 fixed priority, 01 round-robin, 10 forced, 11 treated as 00
- force_sel  input  sel_width  channel used in forced mode

Behaviour:
- Reset: out_valid=0, out_data=0, out_sel=0, rr_ptr=0. in_ready is all-zero whenever rst=1.
- load_en = !out_valid || out_ready. The output register may load only when load_en=1.
- Grant is a combinational one-hot vector over channels with in_valid=1:
  - fixed: lowest valid index wins.
  - round-robin: first valid index scanning upward from rr_ptr, wrapping num_inputs-1 -> 0.
  - forced: only force_sel is granted, and only if that channel is valid; force_sel >= num_inputs grants nothing.
- in_ready[i] = load_en && grant[i] && !rst. At most one bit is high. in_ready never depends combinationally on in_valid of its own channel beyond grant selection.
- Transfer from channel g at a rising edge:
  - out_data <= in_data[g], out_sel <= g, out_valid <= 1.
  - rr_ptr <= (g+1) mod num_inputs. This update happens in all modes.
- If load_en=1 and no grant: out_valid <= 0; out_data and out_sel hold their values.
- If load_en=0: all output registers and rr_ptr hold. out_data and out_sel stay stable while out_valid=1 and out_ready=0.
- Latency is 1 cycle from input handshake to out_valid.
- Throughput is 1 transfer per cycle when out_ready is held high. Back-to-back drain and refill happen in the same cycle.
- Simultaneous out_ready=1 and a new grant: the old word is consumed and the new word is loaded at the same edge, with no bubble.
- mode and force_sel changes take effect at the next grant decision (same cycle, combinational). A word already held in the output register is never altered or dropped.
- Reset mid-operation: the held output is discarded (out_valid=0), rr_ptr=0, and no input handshake completes during the rst cycle.
- Non-power-of-2 num_inputs: round-robin wrap uses num_inputs, not 2^sel_width.
- The block has no data width conversion; out_data width equals width.

Test Plan:
- Fixed mode, num_inputs=4, in_valid=4'b1010, out_ready=1:
  - in_ready=4'b0010.
  - Next cycle: out_sel=1, out_data=ch1 data, out_valid=1.
  - Channel 1 is served each cycle while it remains valid.
- Round-robin mode, all four channels valid continuously, out_ready=1, starting from reset: out_sel sequence is 0,1,2,3,0,1 on consecutive cycles, and out_valid stays high with no bubbles.
- Backpressure: out_valid=1 holding 0xDEADBEEF, out_ready=0 for 3 cycles with in_valid=4'b1111:
  - in_ready=0 for those 3 cycles, and out_data stays 0xDEADBEEF.
  - When out_ready rises, the next grant loads in the same cycle.
- Forced mode:
  - force_sel=2 with in_valid=4'b0011: no grant, and out_valid falls to 0 after the pending word drains.
  - Then assert in_valid[2] with data 0x12345678: out_sel=2, out_data=0x12345678 one cycle later.
- Reset mid-stream: assert rst while out_valid=1 and in_valid=4'b1111.
  - Same edge: out_valid=0, out_data=0, out_sel=0. in_ready=0 during rst.
  - After release in round-robin mode, the first grant is channel 0.
- num_inputs=3 round-robin, all channels valid: sequence is 0,1,2,0, and index 3 is never produced.

Source files
------------

// File: rtl/stream_mux_arb_v2.sv
// stream_mux_arb_v2: registered N-to-1 valid/ready stream mux with fixed, round-robin or forced selection
module stream_mux_arb_v2 #(
  parameter int width = 32,
  parameter int num_inputs = 4,
  localparam int sel_width = (num_inputs > 1) ? $clog2(num_inputs) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [num_inputs*width-1:0] in_data,
  input  logic [num_inputs-1:0]       in_valid,
  output logic [num_inputs-1:0]       in_ready,
  output logic [width-1:0]            out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [sel_width-1:0]        out_sel,
  input  logic [1:0]                  mode,
  input  logic [sel_width-1:0]        force_sel
);
  localparam int slots = 2 ** sel_width;
  logic [slots-1:0] valid_pad;
  logic [width-1:0] ch [slots];
  logic [sel_width-1:0] rr_ptr, gnt_idx, cand;
  logic gnt_found, load_en;
  function automatic logic [sel_width-1:0] wrap(input logic [sel_width-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    return sel_width'(s >= num_inputs ? s - num_inputs : s);
  endfunction
  assign valid_pad = slots'(in_valid);
  genvar i;
  generate
    for (i = 0; i < slots; i++) begin : g_ch
      if (i < num_inputs) begin : g_in
        assign ch[i] = in_data[i*width +: width];
      end else begin : g_pad
        assign ch[i] = '0;
      end
    end
  endgenerate
  assign load_en = !out_valid || out_ready;
  // descending scan so the last hit is the first candidate in priority order
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx = '0;
    cand = '0;
    if (mode == 2'b10) begin
      gnt_idx = force_sel;
      gnt_found = (int'(force_sel) < num_inputs) && valid_pad[force_sel];
    end else begin
      for (int k = num_inputs - 1; k >= 0; k--) begin
        cand = (mode == 2'b01) ? wrap(rr_ptr, k) : sel_width'(k);
        if (valid_pad[cand]) begin
          gnt_found = 1'b1;
          gnt_idx = cand;
        end
      end
    end
  end
  assign in_ready = (load_en && gnt_found && !rst) ? num_inputs'(1) << gnt_idx : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_sel <= '0;
      rr_ptr <= '0;
    end else if (load_en) begin
      out_valid <= gnt_found;
      if (gnt_found) begin
        out_data <= ch[gnt_idx];
        out_sel <= gnt_idx;
        rr_ptr <= wrap(gnt_idx, 1);
      end
    end
  end
endmodule
